// File: rtl/echo_proximity_frontend.sv
// Ultrasonic ranging front end: fires a shared trigger, times three echo pulses and
// produces debounced near flags for the downstream obstacle-warning FSM.
module echo_proximity_frontend #(
    parameter int CNT_W      = 16,
    parameter int TRIG_CYC   = 10,
    parameter int LISTEN_CYC = 2000,
    parameter int GAP_CYC    = 500,
    parameter int THRESH     = 640,
    parameter int HITS       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] echo,
    output logic       trig,
    output logic [2:0] near,
    output logic       frame_done
);

    localparam int DC_W = $clog2(HITS + 1);

    typedef enum logic [1:0] {GAP, TRIG, LISTEN, EVAL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       echo_p0;
    logic [2:0]       echo_p1;
    logic [2:0]       echo_p2;
    logic [2:0]       seen;
    logic [2:0]       done;
    logic [2:0]       hit;
    logic [2:0]       near_nxt;
    logic [CNT_W-1:0] width    [3];
    logic [DC_W-1:0]  dcnt     [3];
    logic [DC_W-1:0]  dcnt_nxt [3];
    logic             frame_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic at_end(input logic [CNT_W-1:0] c, input int len);
        return c == CNT_W'(len - 1);
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            GAP:     if (at_end(cnt, GAP_CYC))    state_nxt = TRIG;
            TRIG:    if (at_end(cnt, TRIG_CYC))   state_nxt = LISTEN;
            LISTEN:  if (at_end(cnt, LISTEN_CYC)) state_nxt = EVAL;
            default: state_nxt = GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= GAP;
        else if (ena)
            state <= state_nxt;
    end

    // A channel only agrees with a flip when its verdict differs from the current flag.
    always_comb begin
        hit      = '0;
        near_nxt = near;
        for (int i = 0; i < 3; i++) begin
            dcnt_nxt[i] = dcnt[i];
            hit[i] = seen[i] & done[i] & (width[i] <= CNT_W'(THRESH));
            if (hit[i] == near[i]) begin
                dcnt_nxt[i] = '0;
            end else if (dcnt[i] == DC_W'(HITS - 1)) begin
                near_nxt[i] = ~near[i];
                dcnt_nxt[i] = '0;
            end else begin
                dcnt_nxt[i] = dcnt[i] + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            trig    <= 1'b0;
            near    <= '0;
            frame_q <= 1'b0;
            echo_p0 <= '0;
            echo_p1 <= '0;
            echo_p2 <= '0;
            seen    <= '0;
            done    <= '0;
            for (int i = 0; i < 3; i++) begin
                width[i] <= '0;
                dcnt[i]  <= '0;
            end
        end else if (ena) begin
            // echo_p1 is the synchronised echo; echo_p2 is its previous value for edge detection
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;
            cnt     <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            trig    <= (state_nxt == TRIG);
            frame_q <= (state == EVAL);
            if (state == EVAL) begin
                near <= near_nxt;
                for (int i = 0; i < 3; i++)
                    dcnt[i] <= dcnt_nxt[i];
            end
            for (int i = 0; i < 3; i++) begin
                if (state_nxt == TRIG && state != TRIG) begin
                    seen[i]  <= 1'b0;
                    done[i]  <= 1'b0;
                    width[i] <= '0;
                end else if (state == LISTEN) begin
                    // Only the first pulse that rises inside the window is measured.
                    if (!seen[i] && echo_p1[i] && !echo_p2[i]) begin
                        seen[i]  <= 1'b1;
                        width[i] <= CNT_W'(1);
                    end else if (seen[i] && !done[i]) begin
                        if (echo_p1[i])
                            width[i] <= sat_inc(width[i]);
                        else
                            done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign frame_done = frame_q & ena;

endmodule

// File: tb/tb_echo_proximity_frontend.sv
// Bench for echo_proximity_frontend: frame-level reference model built from the echo history,
// per-cycle output comparison, plus directed frames with hand-computed flag values.
module tb_echo_proximity_frontend;

    localparam int GAP = 8;
    localparam int TRG = 4;
    localparam int LIS = 40;
    localparam int PER = GAP + TRG + LIS + 1;
    localparam int TH  = 10;
    localparam int HT  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [2:0] echo = 3'b000;
    logic       trig;
    logic [2:0] near;
    logic       frame_done;

    int total = 0;
    int bad = 0;

    echo_proximity_frontend #(
        .CNT_W(16), .TRIG_CYC(TRG), .LISTEN_CYC(LIS), .GAP_CYC(GAP), .THRESH(TH), .HITS(HT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .echo(echo),
        .trig(trig),
        .near(near),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2:0] hist [0:4095];
    int         n = 0;
    logic [2:0] near_m = 3'b000;
    logic       fd_m = 1'b0;
    int         dc_m [3];
    bit         started = 0;

    function automatic logic es_at(input int k, input int c);
        if (k < 2) return 1'b0;
        return hist[k-2][c];
    endfunction

    task automatic eval_frame();
        for (int c = 0; c < 3; c++) begin
            bit found;
            bit h;
            int kr;
            int e;
            found = 0;
            kr = 0;
            h = 0;
            for (int k = n - LIS; k < n; k++)
                if (!found && es_at(k, c) && !es_at(k - 1, c)) begin
                    found = 1;
                    kr = k;
                end
            if (found) begin
                e = kr;
                while (e < n && es_at(e, c)) e++;
                h = (e < n) && ((e - kr) <= TH);
            end
            if (h != near_m[c]) begin
                dc_m[c]++;
                if (dc_m[c] == HT) begin
                    near_m[c] = ~near_m[c];
                    dc_m[c] = 0;
                end
            end else begin
                dc_m[c] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            n = 0;
            near_m = 3'b000;
            fd_m = 1'b0;
            for (int c = 0; c < 3; c++) dc_m[c] = 0;
            started = 1;
        end else if (ena) begin
            hist[n] = echo;
            fd_m = 1'b0;
            if (n % PER == PER - 1) begin
                eval_frame();
                fd_m = 1'b1;
            end
            n++;
        end
    end

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("cyc_trig", {2'b00, trig},
                {2'b00, ((n % PER) >= GAP && (n % PER) < GAP + TRG)});
            chk("cyc_near", near, near_m);
            chk("cyc_frame_done", {2'b00, frame_done}, {2'b00, fd_m & ena});
        end
    end

    // frame_done spacing, measured in clock cycles including frozen ones
    int cyc = 0;
    int last_fd = -1;
    int fd_gap = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) last_fd = -1;
        else if (frame_done === 1'b1) begin
            if (last_fd >= 0) fd_gap = cyc - last_fd;
            last_fd = cyc;
        end
    end

    // ---------------- stimulus ----------------
    int   rise_p;
    int   hi_cnt;
    logic trig_prev;

    function automatic logic on(input int p, input int s, input int w);
        return (w > 0) && (p >= GAP + TRG + s) && (p < GAP + TRG + s + w);
    endfunction

    // Starts at cycle 0 of a frame (1 time unit after its opening edge) and ends likewise.
    task automatic run_frame(input int s0, input int w0, input int s1, input int w1,
                             input int s2, input int w2, input logic [2:0] hold,
                             input int s0b, input int w0b, input int pause_at, input int rst_at);
        rise_p = -1;
        hi_cnt = 0;
        trig_prev = 1'b0;
        for (int p = 0; p < PER; p++) begin
            if (p == pause_at) begin
                ena = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                ena = 1'b1;
            end
            echo[0] = on(p, s0, w0) | on(p, s0b, w0b) | hold[0];
            echo[1] = on(p, s1, w1) | hold[1];
            echo[2] = on(p, s2, w2) | hold[2];
            if (p == rst_at) begin
                rst_n = 1'b0;
                echo = 3'b000;
                @(posedge clk); #1;
                chk("midrst_near", near, 3'b000);
                chk("midrst_trig", {2'b00, trig}, 3'b000);
                chk("midrst_fd", {2'b00, frame_done}, 3'b000);
                rst_n = 1'b1;
                return;
            end
            if (trig && !trig_prev) rise_p = p;
            if (trig) hi_cnt++;
            trig_prev = trig;
            @(posedge clk); #1;
        end
        echo = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and frame timing
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_near", near, 3'b000);
        chk("rst_trig", {2'b00, trig}, 3'b000);
        chk("rst_fd", {2'b00, frame_done}, 3'b000);
        run_frame(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);
        chk_int("trig_rise_pos", rise_p, 8);
        chk_int("trig_high_cycles", hi_cnt, 4);
        chk("fd_after_f1", {2'b00, frame_done}, 3'b001);
        run_frame(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);

        // 2: two 6-wide hits on channel 0
        run_frame(5, 6, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("ch0_hit1", near, 3'b000);
        chk_int("fd_gap_53", fd_gap, 53);
        run_frame(5, 6, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("ch0_hit2", near, 3'b001);

        // 3: channel 1 at one over the threshold, then exactly at it
        run_frame(5, 6, 5, 11, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("ch1_w11_a", near, 3'b001);
        run_frame(5, 6, 5, 11, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("ch1_w11_b", near, 3'b001);
        run_frame(5, 6, 5, 10, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("ch1_w10_a", near, 3'b001);
        run_frame(5, 6, 5, 10, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("ch1_w10_b", near, 3'b011);

        // 4: raise near[2], then hold echo[2] high through two windows
        run_frame(5, 6, 5, 10, 5, 3, 3'b000, 0, 0, -1, -1);
        chk("ch2_hit1", near, 3'b011);
        run_frame(5, 6, 5, 10, 5, 3, 3'b000, 0, 0, -1, -1);
        chk("ch2_hit2", near, 3'b111);
        run_frame(5, 6, 5, 10, 0, 0, 3'b100, 0, 0, -1, -1);
        chk("ch2_hold1", near, 3'b111);
        run_frame(5, 6, 5, 10, 0, 0, 3'b100, 0, 0, -1, -1);
        chk("ch2_hold2", near, 3'b011);

        // 5: alternating miss/hit on channel 0; one miss is a long pulse plus a short one
        for (int f = 0; f < 6; f++) begin
            if (f == 4)
                run_frame(2, 20, 5, 10, 0, 0, 3'b000, 26, 3, -1, -1);
            else if (f % 2 == 0)
                run_frame(0, 0, 5, 10, 0, 0, 3'b000, 0, 0, -1, -1);
            else
                run_frame(5, 6, 5, 10, 0, 0, 3'b000, 0, 0, -1, -1);
            chk("alt_near", near, 3'b011);
        end

        // 6: ena pause mid-LISTEN, then reset mid-LISTEN with all flags set
        run_frame(5, 6, 5, 10, 0, 0, 3'b000, 0, 0, 25, -1);
        chk("pause_near", near, 3'b011);
        run_frame(5, 6, 5, 10, 5, 3, 3'b000, 0, 0, -1, -1);
        chk("all_hit1", near, 3'b011);
        chk_int("fd_gap_58", fd_gap, 58);
        run_frame(5, 6, 5, 10, 5, 3, 3'b000, 0, 0, -1, -1);
        chk("all_hit2", near, 3'b111);
        run_frame(5, 6, 5, 10, 5, 3, 3'b000, 0, 0, -1, 20);
        run_frame(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("post_rst_quiet", near, 3'b000);
        chk_int("post_rst_rise", rise_p, 8);
        run_frame(5, 6, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("post_rst_hit1", near, 3'b000);
        run_frame(5, 6, 0, 0, 0, 0, 3'b000, 0, 0, -1, -1);
        chk("post_rst_hit2", near, 3'b001);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
